layer_compositor: RTL

//   Arbitrates NUM_LAYERS sprite controllers for the single VGA RGB output.
//   Per pixel, selects the highest-priority non-transparent layer; otherwise outputs background.

---
 rtl/layer_compositor_if.sv | 32 +++
 rtl/layer_compositor.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/layer_compositor_if.sv
// Pixel/priority bus between the sprite/display side and the layer compositor.
interface layer_compositor_if #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 12,
  parameter int IDX_W      = 2
);
  logic                          pix_en;
  logic                          bright;
  logic                          hSync_in;
  logic                          vSync_in;
  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb;
  logic [COLOR_W-1:0]            background;
  logic                          prio_wr;
  logic [NUM_LAYERS*IDX_W-1:0]   prio_wdata;
  logic                          prio_busy;
  logic                          prio_err;
  logic [COLOR_W-1:0]            rgb_out;
  logic                          hSync_out;
  logic                          vSync_out;
  logic [NUM_LAYERS-1:0]         hit_mask;
  logic                          frame_done;

  modport master (
    output pix_en, bright, hSync_in, vSync_in, layer_rgb, background, prio_wr, prio_wdata,
    input  prio_busy, prio_err, rgb_out, hSync_out, vSync_out, hit_mask, frame_done
  );

  modport slave (
    input  pix_en, bright, hSync_in, vSync_in, layer_rgb, background, prio_wr, prio_wdata,
    output prio_busy, prio_err, rgb_out, hSync_out, vSync_out, hit_mask, frame_done
  );
endinterface

// File: rtl/layer_compositor.sv
// Priority compositor for sprite layers: 2-stage pixel pipeline, frame-synchronous
// priority reload, and per-frame collision report against layer 0 (player).
module layer_compositor #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 12,
  parameter int IDX_W      = 2
) (
  input  logic             ClkPort,
  input  logic             Reset,
  layer_compositor_if.slave bus
);
  localparam int N = NUM_LAYERS;

  // S1 pixel stage
  logic [N-1:0][COLOR_W-1:0] s1_rgb;
  logic [COLOR_W-1:0]        s1_bg;
  logic                      s1_bright, s1_hs, s1_vs;

  // S2 / output registers
  logic [COLOR_W-1:0] rgb_q;
  logic               hs_q, vs_q;

  // priority state
  logic [N-1:0][IDX_W-1:0] active, pending;
  logic [N-1:0][IDX_W-1:0] wslot;
  logic                    busy, err, perm_ok;
  logic [N-1:0]            seen;

  // collision state
  logic [N-1:0] opaque, cur_hit, acc, hit_q;
  logic         done_q;

  logic [COLOR_W-1:0] sel;
  logic               found;
  logic               boundary;

  assign wslot    = bus.prio_wdata;
  // s1_vs holds the previously sampled vSync_in, so this is the sync falling edge
  assign boundary = bus.pix_en & ~bus.vSync_in & s1_vs;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_layer
      assign opaque[gi] = (s1_rgb[gi] != s1_bg);
      if (gi == 0) begin : g_player
        assign cur_hit[gi] = 1'b0;
      end else begin : g_other
        assign cur_hit[gi] = s1_bright & opaque[0] & opaque[gi];
      end
    end
  endgenerate

  // walk the active order; first non-transparent layer wins, blanking forces black
  always_comb begin
    sel   = s1_bg;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && opaque[active[k]]) begin
        sel   = s1_rgb[active[k]];
        found = 1'b1;
      end
    end
    if (!s1_bright) sel = '0;
  end

  // accept only writes that name every layer exactly once
  always_comb begin
    seen    = '0;
    perm_ok = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (32'(wslot[k]) >= N || seen[wslot[k]]) perm_ok = 1'b0;
      else seen[wslot[k]] = 1'b1;
    end
  end

  // two-stage pixel pipeline, advancing only on pixel strobes
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      s1_rgb    <= '0;
      s1_bg     <= '0;
      s1_bright <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
    end else if (bus.pix_en) begin
      s1_rgb    <= bus.layer_rgb;
      s1_bg     <= bus.background;
      s1_bright <= bus.bright;
      s1_hs     <= bus.hSync_in;
      s1_vs     <= bus.vSync_in;
      rgb_q     <= sel;
      hs_q      <= s1_hs;
      vs_q      <= s1_vs;
    end
  end

  // priority order: pending write promoted only at a frame boundary; a
  // simultaneous new write lands in pending afterwards and keeps busy set
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < N; k++) active[k] <= IDX_W'(k);
      pending <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (boundary && busy) begin
        active <= pending;
        busy   <= 1'b0;
      end
      if (bus.prio_wr) begin
        if (perm_ok) begin
          pending <= wslot;
          busy    <= 1'b1;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  // collision accumulate; at a boundary the pixel still in S1 closes the old
  // frame, and the boundary pixel itself accumulates on the next strobe
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      acc    <= '0;
      hit_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= boundary;
      if (boundary) begin
        hit_q <= acc | cur_hit;
        acc   <= '0;
      end else if (bus.pix_en) begin
        acc <= acc | cur_hit;
      end
    end
  end

  assign bus.rgb_out    = rgb_q;
  assign bus.hSync_out  = hs_q;
  assign bus.vSync_out  = vs_q;
  assign bus.prio_busy  = busy;
  assign bus.prio_err   = err;
  assign bus.hit_mask   = hit_q;
  assign bus.frame_done = done_q;
endmodule
